alu_cmd_queue: RTL and testbench



---
 rtl/alu_cmd_queue.sv | 149 ++++++++++++++
 tb/tb_alu_cmd_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// ----------------------------------------------------------------------------
// alu_cmd_queue
// Command buffer in front of the 4-bit ALU. Commands {a, b, opcode} arrive
// over a valid/ready handshake and are held in a small circular FIFO. The
// head entry is presented to the ALU one command at a time.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   producer has a command
//   in_ready   out  queue can accept (not full)
//   in_a/in_b  in   4-bit operands
//   in_opcode  in   3-bit ALU opcode (1xx invalid)
//   out_valid  out  head entry is presented (not empty)
//   out_ready  in   ALU consumes the head entry
//   out_a/out_b/out_opcode out  head entry fields
//   count      out  occupancy, 0..DEPTH
//   drop_flag  out  sticky, set when a command was discarded
//
// Optional feature: define ALU_CMD_FILTER_EN to discard accepted commands
// that carry an invalid opcode (1xx) or a divide by zero. Without the macro
// every accepted command is stored and drop_flag is held at 0.
// ----------------------------------------------------------------------------
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_a,
    input  logic [3:0]    in_b,
    input  logic [2:0]    in_opcode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_a,
    output logic [3:0]    out_b,
    output logic [2:0]    out_opcode,
    output logic [CW-1:0] count,
    output logic          drop_flag
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [10:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          accept_s;
    logic          store_s;
    logic          pop_s;
    logic [10:0]   head_s;

    // Handshake qualifiers, all decoded from registered occupancy.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != {CW{1'b0}});
    assign accept_s  = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

`ifdef ALU_CMD_FILTER_EN
    logic bad_cmd_s;
    logic drop_q, drop_d;

    // Invalid opcodes and divide-by-zero are accepted but never stored.
    assign bad_cmd_s = in_opcode[2] || ((in_opcode == 3'b011) && (in_b == 4'd0));
    assign store_s   = accept_s && !bad_cmd_s;

    // Sticky drop indication; only reset clears it.
    always_comb begin
        drop_d = drop_q;
        if (accept_s && bad_cmd_s) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Drop flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_flag = drop_q;
`else
    assign store_s   = accept_s;
    assign drop_flag = 1'b0;
`endif

    // Pointer and occupancy next-state; pointers wrap naturally (power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({store_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head fields read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 11'd0;
            end
        end else if (store_s) begin
            mem_q[wr_ptr_q] <= {in_a, in_b, in_opcode};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign head_s     = mem_q[rd_ptr_q];
    assign out_a      = head_s[10:7];
    assign out_b      = head_s[6:3];
    assign out_opcode = head_s[2:0];
    assign count      = count_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic [2:0]    in_opcode;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_a;
    logic [3:0]    out_b;
    logic [2:0]    out_opcode;
    logic [CW-1:0] count;
    logic          drop_flag;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of commands plus a sticky drop bit.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;
    cmd_t mq[$];
    bit   mdrop;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_opcode(out_opcode),
        .count(count), .drop_flag(drop_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_dropped(input cmd_t c);
`ifdef ALU_CMD_FILTER_EN
        return c.op[2] || (c.op == 3'b011 && c.b == 4'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".out_valid"}, out_valid, (mq.size() != 0) ? 1 : 0);
        check_eq({tag, ".in_ready"},  in_ready,  (mq.size() != DEPTH) ? 1 : 0);
        check_eq({tag, ".count"},     count,     mq.size());
        check_eq({tag, ".drop_flag"}, drop_flag, mdrop ? 1 : 0);
        if (mq.size() != 0) begin
            check_eq({tag, ".out_a"},  out_a,      mq[0].a);
            check_eq({tag, ".out_b"},  out_b,      mq[0].b);
            check_eq({tag, ".out_op"}, out_opcode, mq[0].op);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic cycle(input string tag, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op, input logic r);
        cmd_t c;
        bit   acc;
        bit   pp;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
        out_ready = r;
        @(posedge clk);
        c   = '{a: a, b: b, op: op};
        acc = v && (mq.size() != DEPTH);
        pp  = r && (mq.size() != 0);
        if (pp) void'(mq.pop_front());
        if (acc) begin
            if (is_dropped(c)) mdrop = 1'b1;
            else mq.push_back(c);
        end
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mq.delete();
        mdrop = 1'b0;
        #1;
        check_all("reset");
        check_eq("reset.out_a", out_a, 0);
        check_eq("reset.out_b", out_b, 0);
        check_eq("reset.out_op", out_opcode, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; in_opcode = 3'd0; out_ready = 1'b0;
        #2;
        do_reset();

        // Single push then pop.
        cycle("single_push", 1'b1, 4'd3, 4'd5, 3'b000, 1'b0);
        check_eq("single.out_a_const", out_a, 3);
        cycle("single_pop", 1'b0, 4'd0, 4'd0, 3'b000, 1'b1);
        check_eq("single.count_zero", count, 0);

        // Fill to full with a fifth offered command, then drain in order.
        for (int i = 0; i < 5; i++)
            cycle("fill", 1'b1, 4'(i + 1), 4'(i + 7), 3'(i % 4), 1'b0);
        check_eq("fill.in_ready_low", in_ready, 0);
        check_eq("fill.count_full", count, DEPTH);
        for (int i = 0; i < 4; i++)
            cycle("drain", 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);

        // Simultaneous push/pop at count 2 across pointer wrap.
        cycle("pre2a", 1'b1, 4'd10, 4'd1, 3'b001, 1'b0);
        cycle("pre2b", 1'b1, 4'd11, 4'd2, 3'b010, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle("pushpop", 1'b1, 4'($urandom_range(15)), 4'($urandom_range(1, 15)),
                  3'($urandom_range(3)), 1'b1);
            check_eq("pushpop.count2", count, 2);
        end

        // Full plus pop: pop only, in_ready returns next cycle.
        cycle("top3", 1'b1, 4'd4, 4'd4, 3'b000, 1'b0);
        cycle("top4", 1'b1, 4'd5, 4'd5, 3'b000, 1'b0);
        cycle("fullpop", 1'b1, 4'd6, 4'd6, 3'b000, 1'b1);
        check_eq("fullpop.count3", count, 3);
        check_eq("fullpop.in_ready", in_ready, 1);

        // Randomized traffic, including invalid opcodes and zero divisors.
        for (int i = 0; i < 400; i++)
            cycle("rand", 1'($urandom_range(1)), 4'($urandom_range(15)),
                  4'($urandom_range(15)), 3'($urandom_range(7)), 1'($urandom_range(1)));

        // Mid-operation asynchronous reset with three entries held.
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle("pre_rst", 1'b1, 4'(i + 2), 4'd1, 3'b000, 1'b0);
        #3;
        rst_n = 1'b0;
        mq.delete();
        mdrop = 1'b0;
        #1;
        check_eq("midrst.out_valid", out_valid, 0);
        check_eq("midrst.count", count, 0);
        check_eq("midrst.out_a", out_a, 0);
        check_eq("midrst.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Filter scenario (outcome depends on ALU_CMD_FILTER_EN).
        cycle("filt1", 1'b1, 4'd1, 4'd1, 3'b101, 1'b0);
        cycle("filt2", 1'b1, 4'd2, 4'd0, 3'b011, 1'b0);
        cycle("filt3", 1'b1, 4'd9, 4'd2, 3'b001, 1'b0);
`ifdef ALU_CMD_FILTER_EN
        check_eq("filt.count", count, 1);
        check_eq("filt.out_a", out_a, 9);
        check_eq("filt.drop", drop_flag, 1);
`else
        check_eq("filt.count", count, 3);
        check_eq("filt.drop", drop_flag, 0);
`endif
        for (int i = 0; i < 5; i++)
            cycle("filt_hold", 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
